// File: rtl/calc_seq_if.sv
// rtl/calc_seq_if.sv - operand/result handshake bundle for calc_seq
interface calc_seq_if #(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [1:0]           op;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 div_by_zero;
    logic                 busy;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, div_by_zero, busy
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, div_by_zero, busy
    );
endinterface

// File: rtl/calc_seq.sv
// rtl/calc_seq.sv - sequential add/sub/shift-add mul/restoring div unit
// Optional feature macro: CALC_SEQ_REMAINDER_EN (div returns remainder in upper half)
module calc_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    calc_seq_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 dbz_q, dbz_d;

    logic [WIDTH:0]       step_sum;
    logic [WIDTH:0]       div_shift;
    logic                 div_fits;
    logic [WIDTH-1:0]     div_diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dbz_d    = dbz_q;

        // hi/lo form one 2*WIDTH working register: product (mul) or remainder/quotient (div)
        step_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, b_q});
        div_diff  = div_shift[WIDTH-1:0] - b_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d  = bus.op;
                    a_d   = bus.a;
                    b_d   = bus.b;
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    case (bus.op)
                        OP_ADD: begin
                            result_d = {{(WIDTH-1){1'b0}}, {1'b0, bus.a} + {1'b0, bus.b}};
                            state_d  = DONE;
                        end
                        OP_SUB: begin
                            result_d = {{(WIDTH-1){1'b0}}, {1'b0, bus.a} - {1'b0, bus.b}};
                            state_d  = DONE;
                        end
                        OP_MUL: begin
                            hi_d    = '0;
                            lo_d    = bus.b;
                            state_d = RUN;
                        end
                        default: begin
                            if (bus.b == '0) begin
`ifdef CALC_SEQ_REMAINDER_EN
                                result_d = {bus.a, {WIDTH{1'b0}}};
`else
                                result_d = '0;
`endif
                                dbz_d    = 1'b1;
                                state_d  = DONE;
                            end else begin
                                hi_d    = '0;
                                lo_d    = bus.a;
                                state_d = RUN;
                            end
                        end
                    endcase
                end
            end

            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (op_q == OP_MUL) begin
                    hi_d = step_sum[WIDTH:1];
                    lo_d = {step_sum[0], lo_q[WIDTH-1:1]};
                end else begin
                    hi_d = div_fits ? div_diff : div_shift[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], div_fits};
                end
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (op_q == OP_MUL) begin
                        result_d = {hi_d, lo_d};
                    end else begin
`ifdef CALC_SEQ_REMAINDER_EN
                        result_d = {hi_d, lo_d};
`else
                        result_d = {{WIDTH{1'b0}}, lo_d};
`endif
                    end
                end
            end

            DONE: begin
                // Clearing on release keeps result/div_by_zero meaningful only under out_valid
                if (bus.out_ready) begin
                    state_d  = IDLE;
                    result_d = '0;
                    dbz_d    = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.busy        = (state_q == RUN);
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_calc_seq.sv
// tb/tb_calc_seq.sv - directed self-checking bench for calc_seq (WIDTH 32 and 8)
module tb_calc_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    calc_seq_if #(.WIDTH(32)) if32 ();
    calc_seq_if #(.WIDTH(8))  if8 ();

    calc_seq #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(if32));
    calc_seq #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(if8));

    task automatic issue32(input logic [1:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v);
        if32.op = op_v; if32.a = a_v; if32.b = b_v; if32.in_valid = 1'b1;
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
    endtask

    task automatic issue8(input logic [1:0] op_v, input logic [7:0] a_v, input logic [7:0] b_v);
        if8.op = op_v; if8.a = a_v; if8.b = b_v; if8.in_valid = 1'b1;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
    endtask

    task automatic wait32(output int lat, output int busy_cnt);
        lat = 1; busy_cnt = 0;
        while (!if32.out_valid && lat < 200) begin
            if (if32.busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait8(output int lat);
        lat = 1;
        while (!if8.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic pop32();
        if32.out_ready = 1'b1;
        @(posedge clk); #1;
        if32.out_ready = 1'b0;
    endtask

    task automatic pop8();
        if8.out_ready = 1'b1;
        @(posedge clk); #1;
        if8.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (if32.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", if32.in_ready); end
        checks++; if (if32.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", if32.out_valid); end
        checks++; if (if32.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", if32.busy); end
        checks++; if (if32.result !== 64'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", if32.result); end
        checks++; if (if32.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", if32.div_by_zero); end
        checks++; if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0) begin errors++; $display("FAIL reset8 got in_ready=%b out_valid=%b exp 1/0", if8.in_ready, if8.out_valid); end
    endtask

    task automatic test_add();
        int lat, bc;
        issue32(2'b00, 32'hFFFF_FFFF, 32'h1);
        wait32(lat, bc);
        checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got=%0d exp=1", lat); end
        checks++; if (if32.result !== 64'h1_0000_0000) begin errors++; $display("FAIL add_result got=%h exp=100000000", if32.result); end
        checks++; if (if32.div_by_zero !== 1'b0) begin errors++; $display("FAIL add_dbz got=%b exp=0", if32.div_by_zero); end
        checks++; if (if32.in_ready !== 1'b0) begin errors++; $display("FAIL add_in_ready_done got=%b exp=0", if32.in_ready); end
        pop32();
        checks++; if (if32.in_ready !== 1'b1 || if32.out_valid !== 1'b0) begin errors++; $display("FAIL add_release got in_ready=%b out_valid=%b exp 1/0", if32.in_ready, if32.out_valid); end
    endtask

    task automatic test_sub();
        int lat, bc;
        issue32(2'b01, 32'd3, 32'd5);
        wait32(lat, bc);
        checks++; if (lat !== 1) begin errors++; $display("FAIL sub_latency got=%0d exp=1", lat); end
        checks++; if (if32.result !== 64'h1_FFFF_FFFE) begin errors++; $display("FAIL sub_borrow got=%h exp=1fffffffe", if32.result); end
        pop32();
        issue32(2'b01, 32'd5, 32'd3);
        wait32(lat, bc);
        checks++; if (if32.result !== 64'd2) begin errors++; $display("FAIL sub_plain got=%h exp=2", if32.result); end
        pop32();
    endtask

    task automatic test_mul();
        int lat, bc;
        issue32(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        if32.a = 32'h0; if32.b = 32'h0; if32.op = 2'b00;
        wait32(lat, bc);
        checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency got=%0d exp=33", lat); end
        checks++; if (bc !== 32) begin errors++; $display("FAIL mul_busy_cycles got=%0d exp=32", bc); end
        checks++; if (if32.result !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL mul_max got=%h exp=fffffffe00000001", if32.result); end
        pop32();
        issue32(2'b10, 32'h0, 32'h1234);
        wait32(lat, bc);
        checks++; if (lat !== 33 || if32.result !== 64'h0) begin errors++; $display("FAIL mul_zero got lat=%0d res=%h exp 33/0", lat, if32.result); end
        pop32();
        issue32(2'b10, 32'd7, 32'd6);
        wait32(lat, bc);
        checks++; if (if32.result !== 64'd42) begin errors++; $display("FAIL mul_small got=%h exp=2a", if32.result); end
        pop32();
    endtask

    task automatic test_div();
        int lat;
        logic [15:0] exp_div, exp_dz;
`ifdef CALC_SEQ_REMAINDER_EN
        exp_div = {8'd4, 8'd28};
        exp_dz  = {8'd200, 8'd0};
`else
        exp_div = {8'd0, 8'd28};
        exp_dz  = 16'h0;
`endif
        issue8(2'b11, 8'd200, 8'd7);
        wait8(lat);
        checks++; if (lat !== 9) begin errors++; $display("FAIL div_latency got=%0d exp=9", lat); end
        checks++; if (if8.result !== exp_div) begin errors++; $display("FAIL div_result got=%h exp=%h", if8.result, exp_div); end
        checks++; if (if8.div_by_zero !== 1'b0) begin errors++; $display("FAIL div_dbz got=%b exp=0", if8.div_by_zero); end
        pop8();
        issue8(2'b11, 8'd200, 8'd0);
        wait8(lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL divz_latency got=%0d exp=1", lat); end
        checks++; if (if8.result !== exp_dz) begin errors++; $display("FAIL divz_result got=%h exp=%h", if8.result, exp_dz); end
        checks++; if (if8.div_by_zero !== 1'b1) begin errors++; $display("FAIL divz_flag got=%b exp=1", if8.div_by_zero); end
        pop8();
        checks++; if (if8.div_by_zero !== 1'b0) begin errors++; $display("FAIL divz_clear got=%b exp=0", if8.div_by_zero); end
        issue8(2'b00, 8'hFF, 8'hFF);
        wait8(lat);
        checks++; if (lat !== 1 || if8.result !== 16'h01FE) begin errors++; $display("FAIL add8 got lat=%0d res=%h exp 1/01fe", lat, if8.result); end
        pop8();
    endtask

    task automatic test_backpressure();
        int lat, bc;
        int bad = 0;
        issue32(2'b00, 32'd100, 32'd23);
        wait32(lat, bc);
        for (int i = 0; i < 10; i++) begin
            if32.a = $urandom; if32.b = $urandom; if32.op = 2'(i); if32.in_valid = i[0];
            @(posedge clk); #1;
            if (if32.result !== 64'd123 || if32.in_ready !== 1'b0 || if32.out_valid !== 1'b1) bad++;
        end
        if32.in_valid = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got bad_cycles=%0d exp=0 (result=%h)", bad, if32.result); end
        pop32();
        checks++; if (if32.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got in_ready=%b exp=1", if32.in_ready); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        issue32(2'b00, 32'd10, 32'd20);
        wait32(lat, bc);
        if32.op = 2'b00; if32.a = 32'd1; if32.b = 32'd1; if32.in_valid = 1'b1;
        if32.out_ready = 1'b1;
        @(posedge clk); #1;
        if32.out_ready = 1'b0;
        checks++; if (if32.out_valid !== 1'b0 || if32.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_no_reaccept got out_valid=%b in_ready=%b exp 0/1", if32.out_valid, if32.in_ready); end
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
        checks++; if (if32.out_valid !== 1'b1 || if32.result !== 64'd2) begin errors++; $display("FAIL b2b_second got out_valid=%b res=%h exp 1/2", if32.out_valid, if32.result); end
        pop32();
    endtask

    task automatic test_reset_mid_mul();
        int seen = 0;
        issue32(2'b10, 32'd12345, 32'd678);
        repeat (9) @(posedge clk);
        #1;
        checks++; if (if32.busy !== 1'b1) begin errors++; $display("FAIL rmm_running got busy=%b exp=1", if32.busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (if32.in_ready !== 1'b1 || if32.out_valid !== 1'b0 || if32.busy !== 1'b0 || if32.result !== 64'h0 || if32.div_by_zero !== 1'b0)
            begin errors++; $display("FAIL rmm_idle got rdy=%b ov=%b busy=%b res=%h dbz=%b exp 1/0/0/0/0", if32.in_ready, if32.out_valid, if32.busy, if32.result, if32.div_by_zero); end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (if32.out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rmm_no_out_valid got=%0d exp=0", seen); end
        if32.op = 2'b00; if32.a = 32'd5; if32.b = 32'd5; if32.in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; if32.in_valid = 1'b0;
        checks++; if (if32.in_ready !== 1'b1 || if32.out_valid !== 1'b0) begin errors++; $display("FAIL rst_priority got rdy=%b ov=%b exp 1/0", if32.in_ready, if32.out_valid); end
    endtask

    initial begin
        if32.in_valid = 1'b0; if32.out_ready = 1'b0; if32.a = '0; if32.b = '0; if32.op = '0;
        if8.in_valid = 1'b0;  if8.out_ready = 1'b0;  if8.a = '0;  if8.b = '0;  if8.op = '0;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
